// File: rtl/serial_nibble_deserializer.sv
// Framed serial-to-parallel deserializer with optional even-parity check.
// Only complete, parity-clean words reach pdata; aborted or bad frames pulse an error flag instead.
module serial_nibble_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] pdata,
  output logic             pload,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_par;
  logic [WIDTH-1:0] r_pdata;
  logic             r_pload;
  logic             r_perr;
  logic             r_ferr;
  logic             r_busy;
  logic [WIDTH-1:0] w_next_shift;

  assign w_next_shift = MSB_FIRST ? {r_shift[WIDTH-2:0], sin} : {sin, r_shift[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_pdata <= '0;
      r_pload <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_pload <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      if (frame_start) begin
        // frame_start outranks a same-cycle data bit; mid-frame it aborts and restarts
        r_ferr  <= (r_state != S_IDLE);
        r_state <= S_SHIFT;
        r_shift <= '0;
        r_cnt   <= '0;
        r_par   <= 1'b0;
        r_busy  <= 1'b1;
      end else if (sin_valid) begin
        case (r_state)
          S_SHIFT: begin
            r_shift <= w_next_shift;
            r_par   <= r_par ^ sin;
            if (r_cnt == CW'(WIDTH-1)) begin
              if (PARITY_EN) begin
                r_state <= S_PARITY;
              end else begin
                r_pdata <= w_next_shift;
                r_pload <= 1'b1;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_PARITY: begin
            if ((r_par ^ sin) == 1'b0) begin
              r_pdata <= r_shift;
              r_pload <= 1'b1;
            end else begin
              r_perr  <= 1'b1;
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign pdata      = r_pdata;
  assign pload      = r_pload;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;
endmodule

// File: tb/tb_serial_nibble_deserializer.sv
// Randomized scoreboard bench: two deserializer instances (MSB-first with parity, LSB-first without)
// against a frame-level reference model; a negedge monitor checks pulses, pdata and busy.
module tb_serial_nibble_deserializer;
  localparam int W = 4;

  typedef struct {
    int       dut;
    logic [2:0] pulses;   // {pload, parity_err, frame_err}
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic fs[2], sn[2], sv[2];
  logic [W-1:0] pd[2];
  logic pl[2], pe[2], fe[2], bz[2];

  always #5 clk = ~clk;

  serial_nibble_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .frame_start(fs[0]), .sin(sn[0]), .sin_valid(sv[0]),
    .pdata(pd[0]), .pload(pl[0]), .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0]));

  serial_nibble_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .frame_start(fs[1]), .sin(sn[1]), .sin_valid(sv[1]),
    .pdata(pd[1]), .pload(pl[1]), .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1]));

  // Reference model: per-instance frame activity, collected bits and last good word
  bit           msbf[2] = '{1'b1, 1'b0};
  int           pen[2]  = '{1, 0};
  bit           mdl_act[2];
  int           mcnt[2];
  bit           mbits[2][W+1];
  logic [W-1:0] mdl_pd[2];
  exp_t         q[$];
  bit           mon_en = 1'b0;
  int           nchecks = 0;
  int           nfails  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(int d, logic [2:0] p);
    exp_t e;
    e.dut = d;
    e.pulses = p;
    q.push_back(e);
  endtask

  task automatic finish_frame(int d);
    logic [W-1:0] word;
    int ones;
    word = '0;
    ones = 0;
    for (int i = 0; i < W; i++) begin
      ones += int'(mbits[d][i]);
      if (msbf[d]) word[W-1-i] = mbits[d][i];
      else         word[i]     = mbits[d][i];
    end
    if (pen[d] == 1 && ((ones + int'(mbits[d][W])) % 2) != 0) begin
      push(d, 3'b010);
    end else begin
      push(d, 3'b100);
      mdl_pd[d] = word;
    end
    mdl_act[d] = 1'b0;
  endtask

  // One clock of stimulus to instance d; the model advances right after the edge.
  task automatic cyc(int d, bit f, bit v, bit s, bit r);
    for (int k = 0; k < 2; k++) begin
      fs[k] = 1'b0; sv[k] = 1'b0; sn[k] = 1'($urandom_range(0, 1));
    end
    fs[d] = f; sv[d] = v; sn[d] = s; rst = r;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        mdl_act[k] = 1'b0; mcnt[k] = 0; mdl_pd[k] = '0;
      end
    end else if (f) begin
      if (mdl_act[d]) push(d, 3'b001);
      mdl_act[d] = 1'b1;
      mcnt[d] = 0;
    end else if (v && mdl_act[d]) begin
      mbits[d][mcnt[d]] = s;
      mcnt[d]++;
      if (mcnt[d] == W + pen[d]) finish_frame(d);
    end
    #1;
  endtask

  // Bits given in transmission order, first bit leftmost in the n-bit field
  task automatic frame(int d, logic [15:0] bits, int n, int gap);
    cyc(d, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      cyc(d, 1'b0, 1'b1, bits[n-1-i], 1'b0);
      if (i != n - 1) for (int g = 0; g < gap; g++) cyc(d, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [2:0] act;
        exp_t e;
        act = {pl[d], pe[d], fe[d]};
        check($sformatf("busy[%0d]", d), 32'(bz[d]), 32'(mdl_act[d]));
        check($sformatf("pdata[%0d]", d), 32'(pd[d]), 32'(mdl_pd[d]));
        if (act != 3'b000) begin
          if (q.size() == 0 || q[0].dut != d) begin
            check($sformatf("unexpected_pulse[%0d]", d), 32'(act), 32'(0));
          end else begin
            e = q.pop_front();
            check($sformatf("pulse[%0d]", d), 32'(act), 32'(e.pulses));
          end
        end
      end
      if (q.size() != 0) begin
        check("missing_pulse", 32'(0), 32'(q[0].pulses));
        q.delete();
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      fs[k] = 1'b0; sv[k] = 1'b0; sn[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_pdata[%0d]", d), 32'(pd[d]), 32'(0));
      check($sformatf("rst_busy[%0d]", d), 32'(bz[d]), 32'(0));
      check($sformatf("rst_pulses[%0d]", d), 32'({pl[d], pe[d], fe[d]}), 32'(0));
    end

    // Good frame 1011 with parity 1, then bad-parity frame 0110 / 1
    frame(0, 16'b10111, 5, 0);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("good_frame_pdata", 32'(pd[0]), 32'(4'b1011));
    frame(0, 16'b01101, 5, 0);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("parity_err_pdata_held", 32'(pd[0]), 32'(4'b1011));

    // LSB-first, no parity, three idle cycles between bits
    frame(1, 16'b1000, 4, 3);
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lsb_gap_pdata", 32'(pd[1]), 32'(4'b0001));

    // Abort/restart: frame_start with a same-cycle valid bit discards that bit
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 4; i >= 0; i--) cyc(0, 1'b0, 1'b1, (i == 3 || i == 1), 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_restart_pdata", 32'(pd[0]), 32'(4'b0101));

    // Reset mid-frame, stray bit afterwards, then a clean frame
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("reset_mid_frame_pdata", 32'(pd[0]), 32'(0));
    check("reset_mid_frame_busy", 32'(bz[0]), 32'(0));
    frame(0, 16'b10010, 5, 0);
    // frame_start immediately after the final bit is a normal start
    frame(0, 16'b11000, 5, 0);
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("back_to_back_pdata", 32'(pd[0]), 32'(4'b1100));

    // IDLE noise: valid toggling without frame_start
    for (int i = 0; i < 20; i++) cyc(i % 2, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int d;
      d = (i / 40) % 2;
      cyc(d, ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 65),
          1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
    end

    repeat (4) cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("queue_drained", 32'(q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
